video_timing_gen: RTL

Parametrised raster timing generator for the DVI/VGA output path, successor to the fixed 640x480 generator. It produces sync, data-enable and screen coordinates for any porch/sync/active geometry, with configurable sync polarity. It also maps a centred, integer-scaled source window (default Game Boy 160x144 at 3x) to source-pixel coordinates with grid flags. A synchronous genlock input restarts the raster so the output frame can be locked to the emulator frame.

---
 rtl/video_timing_pkg.sv | 30 +++
 rtl/video_timing_gen_if.sv | 27 ++
 rtl/scale_counter.sv | 50 +++++
 rtl/video_timing_gen.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared raster geometry definitions for the video timing generator and its users.
package video_timing_pkg;

  typedef struct packed {
    int unsigned h_act;
    int unsigned h_front;
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned v_act;
    int unsigned v_front;
    int unsigned v_sync;
    int unsigned v_back;
  } geom_t;

  localparam geom_t VGA_640x480 = '{
    h_act: 640, h_front: 16, h_sync: 96,  h_back: 48,
    v_act: 480, v_front: 10, v_sync: 2,   v_back: 33
  };

  localparam geom_t SVGA_800x600 = '{
    h_act: 800, h_front: 40, h_sync: 128, h_back: 88,
    v_act: 600, v_front: 1,  v_sync: 4,   v_back: 23
  };

  function automatic int unsigned total_len(input int unsigned act, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
    return act + front + sync + back;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster output bundle: the generator drives timing/coordinates, the consumer drives genlock.
interface video_timing_gen_if #(
  parameter int unsigned CW = 12
);
  logic          genlock;
  logic          hs;
  logic          vs;
  logic          de;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          win_en;
  logic [7:0]    src_x;
  logic [7:0]    src_y;
  logic          grid;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  genlock,
    output hs, vs, de, x, y, win_en, src_x, src_y, grid, line_start, frame_start
  );

  modport slave (
    output genlock,
    input  hs, vs, de, x, y, win_en, src_x, src_y, grid, line_start, frame_start
  );
endinterface

// File: rtl/scale_counter.sv
// Divider-free upscale tracker: sub counts 0..SCALE-1, idx advances on each sub wrap.
module scale_counter #(
  parameter int unsigned SCALE = 3,
  parameter int unsigned IW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [2:0]    sub_o,
  output logic [IW-1:0] idx_o,
  output logic          wrap_o
);
  localparam logic [2:0] SubLast = 3'(SCALE - 1);

  logic [2:0]    sub_q, sub_d;
  logic [IW-1:0] idx_q, idx_d;

  assign wrap_o = en_i && (sub_q == SubLast);

  always_comb begin
    sub_d = sub_q;
    idx_d = idx_q;
    if (clr_i) begin
      sub_d = '0;
      idx_d = '0;
    end else if (en_i) begin
      if (sub_q == SubLast) begin
        sub_d = '0;
        idx_d = idx_q + 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_q <= '0;
      idx_q <= '0;
    end else begin
      sub_q <= sub_d;
      idx_q <= idx_d;
    end
  end

  assign sub_o = sub_q;
  assign idx_o = idx_q;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with centred integer-scaled source window and genlock.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACT   = VGA_640x480.h_act,
  parameter int unsigned H_FRONT = VGA_640x480.h_front,
  parameter int unsigned H_SYNC  = VGA_640x480.h_sync,
  parameter int unsigned H_BACK  = VGA_640x480.h_back,
  parameter int unsigned V_ACT   = VGA_640x480.v_act,
  parameter int unsigned V_FRONT = VGA_640x480.v_front,
  parameter int unsigned V_SYNC  = VGA_640x480.v_sync,
  parameter int unsigned V_BACK  = VGA_640x480.v_back,
  parameter logic        HS_POL  = 1'b0,
  parameter logic        VS_POL  = 1'b0,
  parameter int unsigned WIN_W   = 160,
  parameter int unsigned WIN_H   = 144,
  parameter int unsigned SCALE   = 3,
  parameter int unsigned CW      = 12
) (
  input  logic               clk,
  input  logic               reset,
  video_timing_gen_if.master vid_io
);
  localparam int unsigned H_TOTAL = total_len(H_ACT, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = total_len(V_ACT, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned WIN_X0  = (H_ACT - WIN_W * SCALE) / 2;
  localparam int unsigned WIN_Y0  = (V_ACT - WIN_H * SCALE) / 2;

  localparam logic [CW-1:0] HLast = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HAct  = CW'(H_ACT);
  localparam logic [CW-1:0] VAct  = CW'(V_ACT);
  localparam logic [CW-1:0] HsBeg = CW'(H_ACT + H_FRONT);
  localparam logic [CW-1:0] HsEnd = CW'(H_ACT + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VsBeg = CW'(V_ACT + V_FRONT);
  localparam logic [CW-1:0] VsEnd = CW'(V_ACT + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] WinX0 = CW'(WIN_X0);
  localparam logic [CW-1:0] WinX1 = CW'(WIN_X0 + WIN_W * SCALE);
  localparam logic [CW-1:0] WinY0 = CW'(WIN_Y0);
  localparam logic [CW-1:0] WinY1 = CW'(WIN_Y0 + WIN_H * SCALE);

  if (WIN_W * SCALE > H_ACT || WIN_H * SCALE > V_ACT) begin : g_bad_window
    $error("scaled window does not fit in the active area");
  end
  if (SCALE < 1 || SCALE > 7) begin : g_bad_scale
    $error("SCALE must be in 1..7");
  end
  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
    $error("CW too narrow for the raster totals");
  end

  // [0],[1] synchroniser, [2] previous value for edge detection
  logic [2:0] gl_q;
  logic       gl_rise;

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          de_c, in_wx, in_wy, win_c, line_next, frame_next;

  logic [2:0] sx_sub, sy_sub;
  logic [7:0] sx_idx, sy_idx;
  logic       sx_wrap, sy_wrap;
  logic       unused_wrap;

  logic          hs_q, vs_q, de_q, win_q, grid_q, ls_q, fs_q;
  logic [CW-1:0] x_q, y_q;
  logic [7:0]    src_x_q, src_y_q;

  assign gl_rise = gl_q[1] & ~gl_q[2];

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == HLast) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
    end
    // A restart while (0,0) is already current would only repeat frame_start.
    if (gl_rise && !(h_q == '0 && v_q == '0)) begin
      h_d = '0;
      v_d = '0;
    end
  end

  assign line_next  = (h_d == '0);
  assign frame_next = line_next && (v_d == '0);

  assign de_c  = (h_q < HAct) && (v_q < VAct);
  assign in_wx = (h_q >= WinX0) && (h_q < WinX1);
  assign in_wy = (v_q >= WinY0) && (v_q < WinY1);
  assign win_c = de_c && in_wx && in_wy;

  scale_counter #(
    .SCALE (SCALE),
    .IW    (8)
  ) u_sx (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (line_next),
    .en_i   (win_c),
    .sub_o  (sx_sub),
    .idx_o  (sx_idx),
    .wrap_o (sx_wrap)
  );

  scale_counter #(
    .SCALE (SCALE),
    .IW    (8)
  ) u_sy (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (frame_next),
    .en_i   (line_next && in_wy),
    .sub_o  (sy_sub),
    .idx_o  (sy_idx),
    .wrap_o (sy_wrap)
  );

  assign unused_wrap = sx_wrap ^ sy_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gl_q    <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      win_q   <= 1'b0;
      src_x_q <= '0;
      src_y_q <= '0;
      grid_q  <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      gl_q    <= {gl_q[1:0], vid_io.genlock};
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= ((h_q >= HsBeg) && (h_q < HsEnd)) ? HS_POL : ~HS_POL;
      vs_q    <= ((v_q >= VsBeg) && (v_q < VsEnd)) ? VS_POL : ~VS_POL;
      de_q    <= de_c;
      x_q     <= de_c ? h_q : '0;
      y_q     <= de_c ? v_q : '0;
      win_q   <= win_c;
      src_x_q <= win_c ? sx_idx : '0;
      src_y_q <= in_wy ? sy_idx : '0;
      grid_q  <= win_c && (sx_sub == '0 || sy_sub == '0);
      ls_q    <= (h_q == '0);
      fs_q    <= (h_q == '0) && (v_q == '0);
    end
  end

  assign vid_io.hs          = hs_q;
  assign vid_io.vs          = vs_q;
  assign vid_io.de          = de_q;
  assign vid_io.x           = x_q;
  assign vid_io.y           = y_q;
  assign vid_io.win_en      = win_q;
  assign vid_io.src_x       = src_x_q;
  assign vid_io.src_y       = src_y_q;
  assign vid_io.grid        = grid_q;
  assign vid_io.line_start  = ls_q;
  assign vid_io.frame_start = fs_q;

endmodule
